issue_queue_wakeup: RTL and testbench

- Parametrised, age-ordered, collapsing issue queue for the out-of-order core. Sits between rename/dispatch and the execute stage.
- Holds up to DEPTH micro-ops with two physical source tags each. Marks sources ready from NUM_WAKE parallel writeback broadcasts per cycle.
- Issues the oldest fully-ready entry through a valid/ready handshake. Supports pipeline flush and same-cycle enqueue wakeup bypass, which the previous single-port queue lacked.

---
 rtl/issue_queue_wakeup.sv | 144 ++++++++++++++
 tb/tb_issue_queue_wakeup.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue_wakeup.sv
// Age-ordered collapsing issue queue: tracks source readiness from writeback
// broadcasts and issues the oldest micro-op whose sources are both ready.
module issue_queue_wakeup #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int DEPTH         = 16,
  parameter int NUM_WAKE      = 2,
  parameter int PAYLOAD_BITS  = 64,
  localparam int TAGW = $clog2(NUM_PHYS_REGS),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     flush_in,
  input  logic                     enq_valid_in,
  output logic                     enq_ready_out,
  input  logic [TAGW-1:0]          enq_src1_tag_in,
  input  logic                     enq_src1_rdy_in,
  input  logic [TAGW-1:0]          enq_src2_tag_in,
  input  logic                     enq_src2_rdy_in,
  input  logic [PAYLOAD_BITS-1:0]  enq_payload_in,
  input  logic [NUM_WAKE-1:0]      wake_valid_in,
  input  logic [NUM_WAKE*TAGW-1:0] wake_tag_in,
  output logic                     issue_valid_out,
  input  logic                     issue_ready_in,
  output logic [PAYLOAD_BITS-1:0]  issue_payload_out,
  output logic [TAGW-1:0]          issue_src1_tag_out,
  output logic [TAGW-1:0]          issue_src2_tag_out,
  output logic [CW-1:0]            count_out
);

  logic [CW-1:0]           count_q, count_d;
  logic [DEPTH-1:0]        rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [TAGW-1:0]         tag1_q [DEPTH];
  logic [TAGW-1:0]         tag1_d [DEPTH];
  logic [TAGW-1:0]         tag2_q [DEPTH];
  logic [TAGW-1:0]         tag2_d [DEPTH];
  logic [PAYLOAD_BITS-1:0] pay_q  [DEPTH];
  logic [PAYLOAD_BITS-1:0] pay_d  [DEPTH];

  // View of each slot's upper neighbour, used when the queue collapses
  logic [DEPTH-1:0]        rdy1_up, rdy2_up;
  logic [TAGW-1:0]         tag1_up [DEPTH];
  logic [TAGW-1:0]         tag2_up [DEPTH];
  logic [PAYLOAD_BITS-1:0] pay_up  [DEPTH];

  logic                    sel_found;
  logic [CW-1:0]           sel_idx;
  logic [PAYLOAD_BITS-1:0] sel_pay;
  logic [TAGW-1:0]         sel_tag1, sel_tag2;
  logic                    issue_fire, enq_fire, shift;
  logic [CW-1:0]           enq_slot;

  function automatic logic wake_hit(input logic [TAGW-1:0]          tag,
                                    input logic [NUM_WAKE-1:0]      vld,
                                    input logic [NUM_WAKE*TAGW-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < NUM_WAKE; p++)
      if (vld[p] && (tags[p*TAGW +: TAGW] == tag)) hit = 1'b1;
    return hit;
  endfunction

  for (genvar g = 0; g < DEPTH; g++) begin : g_up
    localparam int UP = (g < DEPTH - 1) ? g + 1 : g;
    assign rdy1_up[g] = rdy1_q[UP];
    assign rdy2_up[g] = rdy2_q[UP];
    assign tag1_up[g] = tag1_q[UP];
    assign tag2_up[g] = tag2_q[UP];
    assign pay_up[g]  = pay_q[UP];
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_pay   = '0;
    sel_tag1  = '0;
    sel_tag2  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((CW'(i) < count_q) && rdy1_q[i] && rdy2_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = CW'(i);
        sel_pay   = pay_q[i];
        sel_tag1  = tag1_q[i];
        sel_tag2  = tag2_q[i];
      end
    end
  end

  assign issue_valid_out    = sel_found && !flush_in;
  assign issue_payload_out  = issue_valid_out ? sel_pay  : '0;
  assign issue_src1_tag_out = issue_valid_out ? sel_tag1 : '0;
  assign issue_src2_tag_out = issue_valid_out ? sel_tag2 : '0;
  assign enq_ready_out      = (count_q < CW'(DEPTH));
  assign count_out          = count_q;
  assign issue_fire         = issue_valid_out && issue_ready_in;
  assign enq_fire           = enq_valid_in && enq_ready_out && !flush_in;
  assign enq_slot           = count_q - CW'(issue_fire);

  always_comb begin
    count_d = flush_in ? '0 : (count_q + CW'(enq_fire) - CW'(issue_fire));
    rdy1_d  = '0;
    rdy2_d  = '0;
    shift   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      shift     = issue_fire && (CW'(i) >= sel_idx);
      tag1_d[i] = shift ? tag1_up[i] : tag1_q[i];
      tag2_d[i] = shift ? tag2_up[i] : tag2_q[i];
      pay_d[i]  = shift ? pay_up[i]  : pay_q[i];
      rdy1_d[i] = (shift ? rdy1_up[i] : rdy1_q[i]) | wake_hit(tag1_d[i], wake_valid_in, wake_tag_in);
      rdy2_d[i] = (shift ? rdy2_up[i] : rdy2_q[i]) | wake_hit(tag2_d[i], wake_valid_in, wake_tag_in);
      // New entries pick up a same-cycle broadcast so they are not missed
      if (enq_fire && (CW'(i) == enq_slot)) begin
        tag1_d[i] = enq_src1_tag_in;
        tag2_d[i] = enq_src2_tag_in;
        pay_d[i]  = enq_payload_in;
        rdy1_d[i] = enq_src1_rdy_in | wake_hit(enq_src1_tag_in, wake_valid_in, wake_tag_in);
        rdy2_d[i] = enq_src2_rdy_in | wake_hit(enq_src2_tag_in, wake_valid_in, wake_tag_in);
      end
      if (CW'(i) >= count_d) begin
        rdy1_d[i] = 1'b0;
        rdy2_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
    end else begin
      count_q <= count_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
    end
  end

  always_ff @(posedge CLK) begin
    tag1_q <= tag1_d;
    tag2_q <= tag2_d;
    pay_q  <= pay_d;
  end

endmodule

// File: tb/tb_issue_queue_wakeup.sv
// Directed bench for issue_queue_wakeup: issued payloads go through a
// scoreboard queue, occupancy/handshake state is compared inline.
module tb_issue_queue_wakeup;
  localparam int TAGW  = 6;
  localparam int DEPTH = 16;
  localparam int NW    = 2;
  localparam int PB    = 64;
  localparam int CW    = 5;

  logic            CLK = 1'b0;
  logic            RESET;
  logic            flush_in;
  logic            enq_valid_in;
  logic            enq_ready_out;
  logic [TAGW-1:0] enq_src1_tag_in;
  logic            enq_src1_rdy_in;
  logic [TAGW-1:0] enq_src2_tag_in;
  logic            enq_src2_rdy_in;
  logic [PB-1:0]   enq_payload_in;
  logic [NW-1:0]   wake_valid_in;
  logic [NW*TAGW-1:0] wake_tag_in;
  logic            issue_valid_out;
  logic            issue_ready_in;
  logic [PB-1:0]   issue_payload_out;
  logic [TAGW-1:0] issue_src1_tag_out;
  logic [TAGW-1:0] issue_src2_tag_out;
  logic [CW-1:0]   count_out;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [PB-1:0] exp_q [$];

  issue_queue_wakeup #(
    .NUM_PHYS_REGS(64), .DEPTH(DEPTH), .NUM_WAKE(NW), .PAYLOAD_BITS(PB)
  ) dut (
    .CLK(CLK), .RESET(RESET), .flush_in(flush_in),
    .enq_valid_in(enq_valid_in), .enq_ready_out(enq_ready_out),
    .enq_src1_tag_in(enq_src1_tag_in), .enq_src1_rdy_in(enq_src1_rdy_in),
    .enq_src2_tag_in(enq_src2_tag_in), .enq_src2_rdy_in(enq_src2_rdy_in),
    .enq_payload_in(enq_payload_in),
    .wake_valid_in(wake_valid_in), .wake_tag_in(wake_tag_in),
    .issue_valid_out(issue_valid_out), .issue_ready_in(issue_ready_in),
    .issue_payload_out(issue_payload_out),
    .issue_src1_tag_out(issue_src1_tag_out), .issue_src2_tag_out(issue_src2_tag_out),
    .count_out(count_out)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic enq(input logic v, input logic [63:0] p,
                     input logic [5:0] t1, input logic r1,
                     input logic [5:0] t2, input logic r2);
    enq_valid_in    = v;
    enq_payload_in  = p;
    enq_src1_tag_in = t1;
    enq_src1_rdy_in = r1;
    enq_src2_tag_in = t2;
    enq_src2_rdy_in = r2;
  endtask

  task automatic wake(input logic [1:0] v, input logic [5:0] t0, input logic [5:0] t1);
    wake_valid_in = v;
    wake_tag_in   = {t1, t0};
  endtask

  // Scoreboard monitor: every handshake must match the next expected payload
  initial begin
    logic [PB-1:0] e;
    forever begin
      @(negedge CLK);
      if (RESET === 1'b1 && issue_valid_out === 1'b1 && issue_ready_in === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", issue_payload_out, 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("issue_payload", issue_payload_out, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b0; flush_in = 1'b0; issue_ready_in = 1'b0;
    enq(1'b0, 64'h0, 6'd0, 1'b0, 6'd0, 1'b0);
    wake(2'b00, 6'd0, 6'd0);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_count", 64'(count_out), 64'd0);
    chk("rst_enq_ready", 64'(enq_ready_out), 64'd1);
    chk("rst_issue_valid", 64'(issue_valid_out), 64'd0);
    RESET = 1'b1;
    cyc();

    // In-order issue of three ready entries
    issue_ready_in = 1'b1;
    exp_q.push_back(64'hA); exp_q.push_back(64'hB); exp_q.push_back(64'hC);
    enq(1'b1, 64'hA, 6'd1, 1'b1, 6'd2, 1'b1); cyc();
    chk("t1_count_a", 64'(count_out), 64'd1);
    enq(1'b1, 64'hB, 6'd1, 1'b1, 6'd2, 1'b1); cyc();
    chk("t1_count_b", 64'(count_out), 64'd1);
    enq(1'b1, 64'hC, 6'd1, 1'b1, 6'd2, 1'b1); cyc();
    chk("t1_count_c", 64'(count_out), 64'd1);
    enq(1'b0, 64'h0, 6'd0, 1'b0, 6'd0, 1'b0); cyc();
    chk("t1_count_end", 64'(count_out), 64'd0);

    // Younger ready entry bypasses older waiting one; wakeup takes one cycle
    enq(1'b1, 64'h10, 6'd5, 1'b0, 6'd6, 1'b1); cyc();
    chk("t2_wait_valid", 64'(issue_valid_out), 64'd0);
    enq(1'b1, 64'h11, 6'd7, 1'b1, 6'd8, 1'b1); cyc();
    exp_q.push_back(64'h11);
    chk("t2_count2", 64'(count_out), 64'd2);
    enq(1'b0, 64'h0, 6'd0, 1'b0, 6'd0, 1'b0); cyc();
    chk("t2_count1", 64'(count_out), 64'd1);
    wake(2'b10, 6'd0, 6'd5);
    #1;
    chk("t2_no_comb_wake", 64'(issue_valid_out), 64'd0);
    cyc();
    wake(2'b00, 6'd0, 6'd0);
    exp_q.push_back(64'h10);
    chk("t2_woken_valid", 64'(issue_valid_out), 64'd1);
    chk("t2_woken_tag1", 64'(issue_src1_tag_out), 64'd5);
    cyc();
    chk("t2_count0", 64'(count_out), 64'd0);

    // Enqueue bypass of a same-cycle broadcast
    issue_ready_in = 1'b0;
    enq(1'b1, 64'h20, 6'd3, 1'b1, 6'd9, 1'b0);
    wake(2'b01, 6'd9, 6'd0);
    cyc();
    enq(1'b0, 64'h0, 6'd0, 1'b0, 6'd0, 1'b0);
    wake(2'b00, 6'd0, 6'd0);
    chk("t3_bypass_valid", 64'(issue_valid_out), 64'd1);
    chk("t3_bypass_tag2", 64'(issue_src2_tag_out), 64'd9);
    chk("t3_bypass_tag1", 64'(issue_src1_tag_out), 64'd3);
    exp_q.push_back(64'h20);
    issue_ready_in = 1'b1; cyc();
    chk("t3_count0", 64'(count_out), 64'd0);
    issue_ready_in = 1'b0;

    // Full queue refuses enqueue even while issuing
    for (int i = 0; i < DEPTH; i++) begin
      enq(1'b1, 64'h100 + 64'(i), 6'd1, 1'b1, 6'd2, 1'b1); cyc();
    end
    chk("t4_full_count", 64'(count_out), 64'd16);
    chk("t4_full_ready", 64'(enq_ready_out), 64'd0);
    enq(1'b1, 64'h200, 6'd1, 1'b1, 6'd2, 1'b1);
    issue_ready_in = 1'b1;
    exp_q.push_back(64'h100);
    cyc();
    chk("t4_refused_count", 64'(count_out), 64'd15);
    chk("t4_ready_again", 64'(enq_ready_out), 64'd1);
    issue_ready_in = 1'b0;
    cyc();
    chk("t4_refill_count", 64'(count_out), 64'd16);
    enq(1'b0, 64'h0, 6'd0, 1'b0, 6'd0, 1'b0);
    for (int i = 1; i < DEPTH; i++) exp_q.push_back(64'h100 + 64'(i));
    exp_q.push_back(64'h200);
    issue_ready_in = 1'b1;
    repeat (DEPTH) cyc();
    chk("t4_drained", 64'(count_out), 64'd0);
    issue_ready_in = 1'b0;

    // Issue from the middle while enqueuing: queue collapses around slot 2
    enq(1'b1, 64'h30, 6'd10, 1'b0, 6'd2, 1'b1); cyc();
    enq(1'b1, 64'h31, 6'd11, 1'b0, 6'd2, 1'b1); cyc();
    enq(1'b1, 64'h32, 6'd1,  1'b1, 6'd2, 1'b1); cyc();
    enq(1'b1, 64'h33, 6'd13, 1'b0, 6'd2, 1'b1); cyc();
    enq(1'b1, 64'h34, 6'd14, 1'b0, 6'd2, 1'b1); cyc();
    chk("t5_count5", 64'(count_out), 64'd5);
    chk("t5_sel_mid", 64'(issue_payload_out), 64'h32);
    enq(1'b1, 64'h35, 6'd15, 1'b0, 6'd2, 1'b1);
    issue_ready_in = 1'b1;
    exp_q.push_back(64'h32);
    cyc();
    issue_ready_in = 1'b0;
    enq(1'b0, 64'h0, 6'd0, 1'b0, 6'd0, 1'b0);
    chk("t5_count_kept", 64'(count_out), 64'd5);
    chk("t5_none_ready", 64'(issue_valid_out), 64'd0);
    wake(2'b11, 6'd10, 6'd11); cyc();
    wake(2'b11, 6'd13, 6'd14); cyc();
    wake(2'b11, 6'd15, 6'd15); cyc();
    wake(2'b00, 6'd0, 6'd0);
    exp_q.push_back(64'h30); exp_q.push_back(64'h31); exp_q.push_back(64'h33);
    exp_q.push_back(64'h34); exp_q.push_back(64'h35);
    issue_ready_in = 1'b1;
    repeat (5) cyc();
    chk("t5_drained", 64'(count_out), 64'd0);
    issue_ready_in = 1'b0;

    // Flush drops everything, including the concurrent enqueue
    for (int i = 0; i < 6; i++) begin
      enq(1'b1, 64'h60 + 64'(i), 6'd1, 1'b1, 6'd2, 1'b1); cyc();
    end
    chk("t6_count6", 64'(count_out), 64'd6);
    enq(1'b1, 64'h6F, 6'd1, 1'b1, 6'd2, 1'b1);
    flush_in = 1'b1;
    issue_ready_in = 1'b1;
    #1;
    chk("t6_flush_no_issue", 64'(issue_valid_out), 64'd0);
    cyc();
    flush_in = 1'b0;
    enq(1'b0, 64'h0, 6'd0, 1'b0, 6'd0, 1'b0);
    chk("t6_flush_count", 64'(count_out), 64'd0);
    chk("t6_flush_ready", 64'(enq_ready_out), 64'd1);
    chk("t6_flush_valid", 64'(issue_valid_out), 64'd0);
    issue_ready_in = 1'b0;

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      enq(1'b1, 64'h40 + 64'(i), 6'd1, 1'b1, 6'd2, 1'b1); cyc();
    end
    enq(1'b0, 64'h0, 6'd0, 1'b0, 6'd0, 1'b0);
    chk("t7_count3", 64'(count_out), 64'd3);
    #2;
    RESET = 1'b0;
    #1;
    chk("t7_async_count", 64'(count_out), 64'd0);
    chk("t7_async_valid", 64'(issue_valid_out), 64'd0);
    chk("t7_async_ready", 64'(enq_ready_out), 64'd1);
    #3;
    RESET = 1'b1;
    cyc();
    enq(1'b1, 64'h50, 6'd0, 1'b0, 6'd4, 1'b1);
    wake(2'b01, 6'd0, 6'd0);
    cyc();
    enq(1'b0, 64'h0, 6'd0, 1'b0, 6'd0, 1'b0);
    wake(2'b00, 6'd0, 6'd0);
    chk("t7_post_count", 64'(count_out), 64'd1);
    chk("t7_tag0_valid", 64'(issue_valid_out), 64'd1);
    exp_q.push_back(64'h50);
    issue_ready_in = 1'b1;
    cyc();
    chk("t7_post_drain", 64'(count_out), 64'd0);
    issue_ready_in = 1'b0;
    cyc();

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
